// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one data-memory port between the core LSU
// (requester 0) and the debug/DMA engine (requester 1). Grants are
// round-robin, with an optional lock that holds the port for a bounded
// burst. Each accepted beat gets a registered response one cycle later.
module dmem_port_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int BURST_MAX = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid_0,
  input  logic              i_req_valid_1,
  output logic              o_req_ready_0,
  output logic              o_req_ready_1,
  input  logic [ADDR_W+1:0] i_req_addr_0,
  input  logic [ADDR_W+1:0] i_req_addr_1,
  input  logic              i_req_wren_0,
  input  logic              i_req_wren_1,
  input  logic [31:0]       i_req_wdata_0,
  input  logic [31:0]       i_req_wdata_1,
  input  logic [3:0]        i_req_bmask_0,
  input  logic [3:0]        i_req_bmask_1,
  input  logic              i_req_lock_0,
  input  logic              i_req_lock_1,
  output logic              o_rsp_valid_0,
  output logic              o_rsp_valid_1,
  output logic [31:0]       o_rsp_rdata_0,
  output logic [31:0]       o_rsp_rdata_1,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_bmask,
  output logic              o_mem_wren,
  input  logic [31:0]       i_mem_rdata
);

  // BURST_MAX is at most 255, so an 8-bit beat counter always suffices.
  localparam int              CNT_W     = 8;
  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(BURST_MAX);

  // Arbitration state.
  logic             r_last_grant;
  logic             r_locked;
  logic             r_lock_owner;
  logic [CNT_W-1:0] r_beat_cnt;

  // Registered responses.
  logic             r_rsp_valid_0;
  logic             r_rsp_valid_1;
  logic [31:0]      r_rsp_rdata_0;
  logic [31:0]      r_rsp_rdata_1;

  // Grant decode and the granted requester's fields.
  logic             w_gnt_0;
  logic             w_gnt_1;
  logic             w_gnt_any;
  logic             w_gnt_id;
  logic [ADDR_W+1:0] w_sel_addr;
  logic [31:0]      w_sel_wdata;
  logic [3:0]       w_sel_bmask;
  logic             w_sel_wren;
  logic             w_sel_lock;
  logic             w_lock_hold;

  // Saturating increment of the burst beat counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    if (cnt >= BURST_LIM) begin
      return BURST_LIM;
    end
    return cnt + 1'b1;
  endfunction

  // The lock only wins a tie while the owner still has burst beats left.
  assign w_lock_hold = r_locked && (r_beat_cnt < BURST_LIM);

  // Grant selection; nothing is granted while reset is high, so the memory
  // never sees a write during reset.
  always_comb begin
    w_gnt_0 = 1'b0;
    w_gnt_1 = 1'b0;
    if (!i_reset) begin
      if (i_req_valid_0 && i_req_valid_1) begin
        if (w_lock_hold) begin
          w_gnt_0 = ~r_lock_owner;
          w_gnt_1 = r_lock_owner;
        end else begin
          w_gnt_0 = r_last_grant;
          w_gnt_1 = ~r_last_grant;
        end
      end else begin
        w_gnt_0 = i_req_valid_0;
        w_gnt_1 = i_req_valid_1;
      end
    end
  end

  assign w_gnt_any     = w_gnt_0 | w_gnt_1;
  assign w_gnt_id      = w_gnt_1;
  assign o_req_ready_0 = w_gnt_0;
  assign o_req_ready_1 = w_gnt_1;

  // Request mux toward the memory port; the port is driven to zero when idle.
  always_comb begin
    w_sel_addr  = i_req_addr_0;
    w_sel_wdata = i_req_wdata_0;
    w_sel_bmask = i_req_bmask_0;
    w_sel_wren  = i_req_wren_0;
    w_sel_lock  = i_req_lock_0;
    if (w_gnt_1) begin
      w_sel_addr  = i_req_addr_1;
      w_sel_wdata = i_req_wdata_1;
      w_sel_bmask = i_req_bmask_1;
      w_sel_wren  = i_req_wren_1;
      w_sel_lock  = i_req_lock_1;
    end
  end

  // Byte address bits [1:0] are dropped: lanes are chosen by the mask.
  assign o_mem_addr  = w_gnt_any ? w_sel_addr[ADDR_W+1:2] : '0;
  assign o_mem_wdata = w_gnt_any ? w_sel_wdata : 32'h0;
  assign o_mem_bmask = w_gnt_any ? w_sel_bmask : 4'h0;
  assign o_mem_wren  = w_gnt_any & w_sel_wren;

  // Round-robin pointer, lock ownership and burst beat counting.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_last_grant <= 1'b1;
      r_locked     <= 1'b0;
      r_lock_owner <= 1'b0;
      r_beat_cnt   <= '0;
    end else if (!w_gnt_any) begin
      r_locked   <= 1'b0;
      r_beat_cnt <= '0;
    end else begin
      r_last_grant <= w_gnt_id;
      if (w_sel_lock) begin
        r_locked     <= 1'b1;
        r_lock_owner <= w_gnt_id;
        if (r_locked && (r_lock_owner == w_gnt_id)) begin
          r_beat_cnt <= sat_inc(r_beat_cnt);
        end else begin
          r_beat_cnt <= CNT_W'(1);
        end
      end else begin
        r_locked   <= 1'b0;
        r_beat_cnt <= '0;
      end
    end
  end

  // One-cycle response per accepted beat; writes return zero as an ack and
  // read data is held until the next response for that requester.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rsp_valid_0 <= 1'b0;
      r_rsp_valid_1 <= 1'b0;
      r_rsp_rdata_0 <= 32'h0;
      r_rsp_rdata_1 <= 32'h0;
    end else begin
      r_rsp_valid_0 <= w_gnt_0;
      r_rsp_valid_1 <= w_gnt_1;
      if (w_gnt_0) begin
        r_rsp_rdata_0 <= i_req_wren_0 ? 32'h0 : i_mem_rdata;
      end
      if (w_gnt_1) begin
        r_rsp_rdata_1 <= i_req_wren_1 ? 32'h0 : i_mem_rdata;
      end
    end
  end

  assign o_rsp_valid_0 = r_rsp_valid_0;
  assign o_rsp_valid_1 = r_rsp_valid_1;
  assign o_rsp_rdata_0 = r_rsp_rdata_0;
  assign o_rsp_rdata_1 = r_rsp_rdata_1;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios followed by randomized
// traffic, with a reference model and response scoreboard.
module tb_dmem_port_arbiter;

  localparam int ADDR_W    = 16;
  localparam int BURST_MAX = 4;

  typedef struct packed {
    logic              v;
    logic              w;
    logic [ADDR_W+1:0] a;
    logic [31:0]       d;
    logic [3:0]        m;
    logic              l;
  } req_t;

  logic              i_clk;
  logic              i_reset;
  logic              i_req_valid_0, i_req_valid_1;
  logic              o_req_ready_0, o_req_ready_1;
  logic [ADDR_W+1:0] i_req_addr_0, i_req_addr_1;
  logic              i_req_wren_0, i_req_wren_1;
  logic [31:0]       i_req_wdata_0, i_req_wdata_1;
  logic [3:0]        i_req_bmask_0, i_req_bmask_1;
  logic              i_req_lock_0, i_req_lock_1;
  logic              o_rsp_valid_0, o_rsp_valid_1;
  logic [31:0]       o_rsp_rdata_0, o_rsp_rdata_1;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [31:0]       o_mem_wdata;
  logic [3:0]        o_mem_bmask;
  logic              o_mem_wren;
  logic [31:0]       i_mem_rdata;

  dmem_port_arbiter #(.ADDR_W(ADDR_W), .BURST_MAX(BURST_MAX)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_req_valid_0(i_req_valid_0), .i_req_valid_1(i_req_valid_1),
    .o_req_ready_0(o_req_ready_0), .o_req_ready_1(o_req_ready_1),
    .i_req_addr_0(i_req_addr_0), .i_req_addr_1(i_req_addr_1),
    .i_req_wren_0(i_req_wren_0), .i_req_wren_1(i_req_wren_1),
    .i_req_wdata_0(i_req_wdata_0), .i_req_wdata_1(i_req_wdata_1),
    .i_req_bmask_0(i_req_bmask_0), .i_req_bmask_1(i_req_bmask_1),
    .i_req_lock_0(i_req_lock_0), .i_req_lock_1(i_req_lock_1),
    .o_rsp_valid_0(o_rsp_valid_0), .o_rsp_valid_1(o_rsp_valid_1),
    .o_rsp_rdata_0(o_rsp_rdata_0), .o_rsp_rdata_1(o_rsp_rdata_1),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_mem_bmask(o_mem_bmask), .o_mem_wren(o_mem_wren),
    .i_mem_rdata(i_mem_rdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Memory attached to the port: combinational read, byte-masked write.
  logic [31:0] env_mem [16] = '{default: 32'h0};
  assign i_mem_rdata = env_mem[o_mem_addr[3:0]];
  always @(posedge i_clk) begin
    if (!i_reset && o_mem_wren) begin
      for (int b = 0; b < 4; b++) begin
        if (o_mem_bmask[b]) env_mem[o_mem_addr[3:0]][8*b +: 8] <= o_mem_wdata[8*b +: 8];
      end
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Reference model state: arbitration rules and a sparse word memory.
  int          m_last   = 1;
  int          m_owner  = 0;
  int          m_cnt    = 0;
  bit          m_locked = 1'b0;
  logic [31:0] ref_mem [int];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];

  function automatic logic [31:0] ref_read(input int word);
    if (ref_mem.exists(word)) return ref_mem[word];
    return 32'h0;
  endfunction

  function automatic req_t mk(input logic v, input logic w, input logic [ADDR_W+1:0] a,
                              input logic [31:0] d, input logic [3:0] m, input logic l);
    req_t r;
    r.v = v; r.w = w; r.a = a; r.d = d; r.m = m; r.l = l;
    return r;
  endfunction

  // One request cycle: drive at the falling edge, check the combinational
  // grant/memory outputs, queue the expected response, advance the model.
  task automatic beat(input bit rst_in, input req_t r0, input req_t r1, input int exp_g);
    int          g;
    int          dg;
    int          word;
    req_t        s;
    logic [31:0] cur;
    @(negedge i_clk);
    i_reset       = rst_in;
    i_req_valid_0 = r0.v; i_req_wren_0 = r0.w; i_req_addr_0 = r0.a;
    i_req_wdata_0 = r0.d; i_req_bmask_0 = r0.m; i_req_lock_0 = r0.l;
    i_req_valid_1 = r1.v; i_req_wren_1 = r1.w; i_req_addr_1 = r1.a;
    i_req_wdata_1 = r1.d; i_req_bmask_1 = r1.m; i_req_lock_1 = r1.l;
    #1;
    if (rst_in)                 g = -1;
    else if (!r0.v && !r1.v)    g = -1;
    else if (r0.v != r1.v)      g = r0.v ? 0 : 1;
    else if (m_locked && m_cnt < BURST_MAX) g = m_owner;
    else                        g = 1 - m_last;

    chk("ready_0", 32'(o_req_ready_0), 32'(g == 0));
    chk("ready_1", 32'(o_req_ready_1), 32'(g == 1));
    if (exp_g != -2) begin
      dg = o_req_ready_0 ? 0 : (o_req_ready_1 ? 1 : -1);
      chk("plan_grant", dg, exp_g);
    end
    s = (g == 1) ? r1 : r0;
    if (g >= 0) begin
      word = int'(s.a) / 4;
      chk("mem_addr",  32'(o_mem_addr),  word);
      chk("mem_wdata", o_mem_wdata,      s.d);
      chk("mem_bmask", 32'(o_mem_bmask), 32'(s.m));
      chk("mem_wren",  32'(o_mem_wren),  32'(s.w));
      if (s.w) begin
        cur = ref_read(word);
        for (int b = 0; b < 4; b++) if (s.m[b]) cur[8*b +: 8] = s.d[8*b +: 8];
        ref_mem[word] = cur;
        if (g == 0) q0.push_back(32'h0); else q1.push_back(32'h0);
      end else begin
        if (g == 0) q0.push_back(ref_read(word)); else q1.push_back(ref_read(word));
      end
    end else begin
      chk("idle_mem", {o_mem_wren, 3'b0, o_mem_bmask, 8'h0, o_mem_addr} | o_mem_wdata, 32'h0);
    end

    if (rst_in) begin
      chk("rst_drop_v", {30'h0, o_rsp_valid_1, o_rsp_valid_0}, 32'h0);
      chk("rst_drop_d", o_rsp_rdata_0 | o_rsp_rdata_1, 32'h0);
      m_last = 1; m_owner = 0; m_cnt = 0; m_locked = 1'b0;
    end else if (g < 0) begin
      m_locked = 1'b0; m_cnt = 0;
    end else begin
      if (s.l) begin
        m_cnt    = (m_locked && m_owner == g) ? ((m_cnt + 1 > BURST_MAX) ? BURST_MAX : m_cnt + 1) : 1;
        m_locked = 1'b1;
        m_owner  = g;
      end else begin
        m_locked = 1'b0; m_cnt = 0;
      end
      m_last = g;
    end
  endtask

  // Response monitor: each cycle after the edge, pop the expected response
  // for any beat accepted on the previous cycle, otherwise expect held data.
  logic [31:0] h0 = 32'h0;
  logic [31:0] h1 = 32'h0;
  logic [31:0] e;
  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      if (i_reset) begin
        q0.delete(); q1.delete();
        h0 = 32'h0; h1 = 32'h0;
        chk("rst_rsp_v", {30'h0, o_rsp_valid_1, o_rsp_valid_0}, 32'h0);
      end else begin
        if (q0.size() > 0) begin
          e = q0.pop_front();
          chk("rsp_valid_0", 32'(o_rsp_valid_0), 32'h1);
          chk("rsp_rdata_0", o_rsp_rdata_0, e);
          h0 = e;
        end else begin
          chk("rsp_valid_0_idle", 32'(o_rsp_valid_0), 32'h0);
          chk("rsp_hold_0", o_rsp_rdata_0, h0);
        end
        if (q1.size() > 0) begin
          e = q1.pop_front();
          chk("rsp_valid_1", 32'(o_rsp_valid_1), 32'h1);
          chk("rsp_rdata_1", o_rsp_rdata_1, e);
          h1 = e;
        end else begin
          chk("rsp_valid_1_idle", 32'(o_rsp_valid_1), 32'h0);
          chk("rsp_hold_1", o_rsp_rdata_1, h1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  req_t idle, ra, rb;
  int   pat_lock [7] = '{0, 1, 1, 1, 1, 0, 1};

  initial begin
    idle = mk(1'b0, 1'b0, '0, 32'h0, 4'h0, 1'b0);
    i_reset = 1'b1;
    i_req_valid_0 = 0; i_req_wren_0 = 0; i_req_addr_0 = '0; i_req_wdata_0 = 0;
    i_req_bmask_0 = 0; i_req_lock_0 = 0;
    i_req_valid_1 = 0; i_req_wren_1 = 0; i_req_addr_1 = '0; i_req_wdata_1 = 0;
    i_req_bmask_1 = 0; i_req_lock_1 = 0;

    beat(1, idle, idle, -1);
    beat(1, idle, idle, -1);
    beat(0, idle, idle, -1);

    // Write then read back word 5.
    beat(0, mk(1, 1, 18'h14, 32'hDEADBEEF, 4'hF, 0), idle, 0);
    beat(0, mk(1, 0, 18'h14, 32'h0, 4'h0, 0), idle, 0);
    @(posedge i_clk); #2;
    chk("plan_read_back", o_rsp_rdata_0, 32'hDEADBEEF);

    // Tie with no lock alternates starting at requester 0.
    beat(1, idle, idle, -1);
    for (int i = 0; i < 6; i++)
      beat(0, mk(1, 0, 18'h14, 0, 0, 0), mk(1, 0, 18'h8, 0, 0, 0), i % 2);

    // Requester 1 locked against a waiting requester 0.
    beat(1, idle, idle, -1);
    for (int i = 0; i < 7; i++)
      beat(0, mk(1, 0, 18'h4, 0, 0, 0), mk(1, 0, 18'hC, 0, 0, 1), pat_lock[i]);

    // Uncontended lock for 10 beats, then requester 1 joins.
    beat(1, idle, idle, -1);
    for (int i = 0; i < 10; i++)
      beat(0, mk(1, 0, 18'h14, 0, 0, 1), idle, 0);
    beat(0, mk(1, 0, 18'h14, 0, 0, 1), mk(1, 0, 18'h14, 0, 0, 0), 1);

    // Byte-mask merge on word 7, with an idle cycle before the read.
    beat(0, mk(1, 1, 18'h1C, 32'h11223344, 4'hF, 0), idle, 0);
    beat(0, idle, mk(1, 1, 18'h1D, 32'hAABBCCDD, 4'h5, 0), 1);
    beat(0, idle, idle, -1);
    beat(0, mk(1, 0, 18'h1E, 32'h0, 4'h0, 0), idle, 0);
    @(posedge i_clk); #2;
    chk("plan_bmask_merge", o_rsp_rdata_0, 32'h11BB33DD);

    // Reset while a read response is outstanding.
    beat(0, mk(1, 0, 18'h14, 0, 0, 0), idle, 0);
    beat(1, mk(1, 1, 18'h0, 32'hFFFFFFFF, 4'hF, 0), idle, -1);
    beat(1, idle, idle, -1);
    beat(0, mk(1, 0, 18'h14, 0, 0, 0), mk(1, 0, 18'h1C, 0, 0, 0), 0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      ra = mk(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              18'($urandom_range(0, 63)), $urandom, 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 2) != 0));
      rb = mk(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              18'($urandom_range(0, 63)), $urandom, 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 2) != 0));
      beat(1'($urandom_range(0, 60) == 0), ra, rb, -2);
    end
    beat(0, idle, idle, -1);
    @(posedge i_clk); #3;
    chk("q_drain", q0.size() + q1.size(), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares one port of the dual-port data memory between two requesters: requester 0 is the core LSU and requester 1 is the debug/DMA engine.
- Each requester uses a valid/ready request channel and receives a registered response one cycle after its request is accepted.
- Arbitration is round-robin with an optional bounded lock for bursts, so neither requester can starve the other.
- The block sits between the requesters and the memory's port B signals. Memory read data is combinational from the address.

Parameters:
- ADDR_W, 16: word-address width of the memory port.
- BURST_MAX, 4: maximum consecutive locked grants while the other requester is waiting (legal range 1..255).

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous active-high reset.
- i_req_valid_0 / i_req_valid_1  in  1  request valid.
- o_req_ready_0 / o_req_ready_1  out  1  request accepted this cycle.
- i_req_addr_0 / i_req_addr_1  in  ADDR_W+2  byte address.
- i_req_wren_0 / i_req_wren_1  in  1  1 = write, 0 = read.
- i_req_wdata_0 / i_req_wdata_1  in  32  write data.
- i_req_bmask_0 / i_req_bmask_1  in  4  byte enables.
- i_req_lock_0 / i_req_lock_1  in  1  request to keep the grant for the next beat.
- o_rsp_valid_0 / o_rsp_valid_1  out  1  response valid, no backpressure.
- o_rsp_rdata_0 / o_rsp_rdata_1  out  32  read data.
- o_mem_addr  out  ADDR_W  word address to the memory port.
- o_mem_wdata  out  32  write data to the memory port.
- o_mem_bmask  out  4  byte mask to the memory port.
- o_mem_wren  out  1  write enable to the memory port.
- i_mem_rdata  in  32  combinational read data from the memory port.

Behaviour:
- Clock and reset: one clock, i_clk. Reset is i_reset, asynchronous and active-high.
- Reset values:
  - o_rsp_valid_*=0 and o_rsp_rdata_*=0.
  - last_grant=1, so requester 0 wins the first tie.
  - locked=0, lock_owner=0, beat_cnt=0.
  - Combinational outputs follow the idle rules below.
- Grant selection, combinational, evaluated each cycle:
  - No valid requests: no grant.
  - Exactly one valid: that requester is granted.
  - Both valid, locked=1 and beat_cnt<BURST_MAX: lock_owner is granted.
  - Both valid otherwise: the requester != last_grant is granted.
- o_req_ready_N=1 exactly when N is granted. At most one ready is high per cycle. Ready may depend combinationally on valid.
- Memory drive:
  - On a grant: o_mem_addr=addr[ADDR_W+1:2]; wdata, bmask and wren come from the granted requester.
  - Idle: o_mem_wren=0, o_mem_bmask=0, o_mem_addr=0, o_mem_wdata=0.
  - addr[1:0] are ignored, because byte lanes are selected by bmask.
- Response timing:
  - o_rsp_valid_N rises on the clock edge after N is granted and is high for exactly 1 cycle per accepted beat.
  - Reads: o_rsp_rdata_N = i_mem_rdata sampled at the grant edge.
  - Writes: o_rsp_rdata_N=0, and the valid acts as a write acknowledge.
  - o_rsp_rdata_* holds its value when valid is 0.
- Lock and counter update, at each edge:
  - No grant: locked<=0, beat_cnt<=0.
  - Grant g with i_req_lock_g=1:
    - locked<=1, lock_owner<=g.
    - If locked && lock_owner==g, beat_cnt<=beat_cnt+1, saturating at BURST_MAX. Otherwise beat_cnt<=1.
  - Grant g with i_req_lock_g=0: locked<=0, beat_cnt<=0.
  - Every grant sets last_grant<=g.
- Burst limit: once beat_cnt reaches BURST_MAX and the other requester is valid, the other requester wins the next cycle. If the other requester is idle, the owner continues and beat_cnt stays saturated.
- Read-after-write: a write and a subsequent read to the same address on back-to-back grants return the new data. The write is committed at the edge, and the read is sampled after it.
- Reset mid-burst or mid-response: all state clears immediately, any pending o_rsp_valid is dropped, and there is no memory write while reset is high. Requesters must reissue their requests.

Test Plan:
- Single read: after reset, write mem[5]=0xDEADBEEF through requester 0 (addr 0x14, bmask 0xF) → ready_0=1 that cycle, rsp_valid_0=1 next cycle with rdata 0. A following read of 0x14 → rsp_rdata_0=0xDEADBEEF one cycle after the grant.
- Tie, round-robin: both requesters continuously valid with no lock for 6 cycles after reset → grants alternate 0,1,0,1,0,1, and each rsp_valid pulses once per own grant.
- Bounded lock: requester 1 has lock=1 continuously and requester 0 is valid throughout, BURST_MAX=4 → requester 1 is granted 4 consecutive cycles, then requester 0, then requester 1 again.
- Lock without contention: requester 0 has lock=1 for 10 beats with requester 1 idle → 10 consecutive grants to requester 0 and beat_cnt saturates at 4. Requester 1 asserts valid at beat 10 → it is granted at the next cycle.
- Byte mask: write 0x11223344 with bmask 0xF, then 0xAABBCCDD with bmask 0x5 to the same word → read returns 0x11BB33DD. Idle cycles show o_mem_wren=0.
- Reset mid-operation: assert i_reset in the cycle after a read grant → rsp_valid is 0 and last_grant=1, and after release simultaneous requests grant requester 0 first.
